// File: rtl/vx_mem_scheduler_pkg.sv
// Shared constants, types and tag helpers for the memory request scheduler.
package vx_mem_scheduler_pkg;

  localparam int NUM_REQS      = 4;
  localparam int ADDR_WIDTH    = 32;
  localparam int DATA_WIDTH    = 64;
  localparam int TAG_IN_WIDTH  = 8;
  localparam int MAX_PENDING   = 4;

  localparam int LOG_NUM_REQS  = $clog2(NUM_REQS);
  localparam int TAG_OUT_WIDTH = TAG_IN_WIDTH + LOG_NUM_REQS;
  // The requester index occupies the MSBs of the outgoing tag.
  localparam int TAG_IDX_LSB   = TAG_IN_WIDTH;
  localparam int TAG_IDX_MSB   = TAG_OUT_WIDTH - 1;
  localparam int PEND_WIDTH    = $clog2(MAX_PENDING + 1);

  typedef logic [LOG_NUM_REQS-1:0]  req_idx_t;
  typedef logic [PEND_WIDTH-1:0]    pend_t;
  typedef logic [TAG_IN_WIDTH-1:0]  tag_in_t;
  typedef logic [TAG_OUT_WIDTH-1:0] tag_out_t;

  // Observable internal state: per-requester credit counters and arbiter pointer.
  typedef struct packed {
    pend_t [NUM_REQS-1:0] pending;
    req_idx_t             ptr;
  } dbg_t;

  function automatic tag_out_t tag_pack(req_idx_t idx, tag_in_t tag);
    return {idx, tag};
  endfunction

  function automatic req_idx_t tag_idx(tag_out_t tag);
    return tag[TAG_IDX_MSB:TAG_IDX_LSB];
  endfunction

endpackage

// File: rtl/vx_mem_scheduler_if.sv
// Bundle of requester-side and memory-side signals of the scheduler.
// Handshake: a transfer happens on a cycle where valid and ready are both
// high; valid never depends on ready, and a source holding valid keeps its
// payload stable until the transfer completes.
interface vx_mem_scheduler_if;
  import vx_mem_scheduler_pkg::*;

  logic [NUM_REQS-1:0]                 req_valid_in;
  logic [NUM_REQS-1:0][ADDR_WIDTH-1:0] req_addr_in;
  logic [NUM_REQS-1:0][TAG_IN_WIDTH-1:0] req_tag_in;
  logic [NUM_REQS-1:0]                 req_ready_in;

  logic                                req_valid_out;
  logic [ADDR_WIDTH-1:0]               req_addr_out;
  logic [TAG_OUT_WIDTH-1:0]            req_tag_out;
  logic                                req_ready_out;

  logic                                rsp_valid_in;
  logic [TAG_OUT_WIDTH-1:0]            rsp_tag_in;
  logic [DATA_WIDTH-1:0]               rsp_data_in;
  logic                                rsp_ready_in;

  logic [NUM_REQS-1:0]                 rsp_valid_out;
  logic [NUM_REQS-1:0][TAG_IN_WIDTH-1:0] rsp_tag_out;
  logic [NUM_REQS-1:0][DATA_WIDTH-1:0] rsp_data_out;
  logic [NUM_REQS-1:0]                 rsp_ready_out;

  dbg_t                                dbg;

  // Scheduler view.
  modport master (
    input  req_valid_in, req_addr_in, req_tag_in, req_ready_out,
    input  rsp_valid_in, rsp_tag_in, rsp_data_in, rsp_ready_out,
    output req_ready_in, req_valid_out, req_addr_out, req_tag_out,
    output rsp_ready_in, rsp_valid_out, rsp_tag_out, rsp_data_out,
    output dbg
  );

  // Environment view (requesters plus memory).
  modport slave (
    output req_valid_in, req_addr_in, req_tag_in, req_ready_out,
    output rsp_valid_in, rsp_tag_in, rsp_data_in, rsp_ready_out,
    input  req_ready_in, req_valid_out, req_addr_out, req_tag_out,
    input  rsp_ready_in, rsp_valid_out, rsp_tag_out, rsp_data_out,
    input  dbg
  );

endinterface

// File: rtl/vx_mem_scheduler_rr_arbiter.sv
// Round-robin arbiter: searches upward from ptr with wrap; ptr moves past
// the winner only when the grant is consumed (enable).
module vx_mem_scheduler_rr_arbiter
  import vx_mem_scheduler_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] requests,
  input  logic                enable,
  output logic [NUM_REQS-1:0] grant,
  output req_idx_t            grant_idx,
  output logic                grant_valid,
  output req_idx_t            ptr
);

  req_idx_t idx;

  // Priority search; descending k so the candidate closest to ptr wins last.
  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int k = NUM_REQS - 1; k >= 0; k--) begin
      idx = req_idx_t'((int'(ptr) + k) % NUM_REQS);
      if (requests[idx]) begin
        grant_idx   = idx;
        grant_valid = 1'b1;
      end
    end
    grant = NUM_REQS'(grant_valid) << grant_idx;
  end

  // Priority pointer advances to the slot after the consumed winner.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (enable) begin
      ptr <= req_idx_t'((int'(grant_idx) + 1) % NUM_REQS);
    end
  end

endmodule

// File: rtl/vx_mem_scheduler.sv
// Shares one memory read port among NUM_REQS requesters with per-requester
// credit limits, a registered request stage and a combinational response
// demultiplexer keyed by the requester index carried in the tag MSBs.
module vx_mem_scheduler
  import vx_mem_scheduler_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  vx_mem_scheduler_if.master  io
);

  pend_t [NUM_REQS-1:0] pending;
  logic  [NUM_REQS-1:0] eligible;
  logic  [NUM_REQS-1:0] grant;
  req_idx_t             grant_idx;
  logic                 grant_valid;
  req_idx_t             ptr;
  logic                 out_ready;
  logic                 accept;
  req_idx_t             sel;
  logic                 rsp_fire;

  // A requester competes only while it still has credit.
  always_comb begin
    for (int i = 0; i < NUM_REQS; i++) begin
      eligible[i] = io.req_valid_in[i] && (pending[i] < pend_t'(MAX_PENDING));
    end
  end

  vx_mem_scheduler_rr_arbiter u_arb (
    .clk         (clk),
    .reset       (reset),
    .requests    (eligible),
    .enable      (accept),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .ptr         (ptr)
  );

  // Output register can take a new request when empty or draining this cycle.
  assign out_ready       = ~io.req_valid_out | io.req_ready_out;
  assign io.req_ready_in = grant & {NUM_REQS{out_ready}};
  assign accept          = grant_valid & out_ready;

  // Registered request stage; holds contents while stalled downstream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      io.req_valid_out <= 1'b0;
      io.req_addr_out  <= '0;
      io.req_tag_out   <= '0;
    end else if (out_ready) begin
      io.req_valid_out <= accept;
      if (accept) begin
        io.req_addr_out <= io.req_addr_in[grant_idx];
        io.req_tag_out  <= tag_pack(grant_idx, io.req_tag_in[grant_idx]);
      end
    end
  end

  assign sel      = tag_idx(io.rsp_tag_in);
  assign rsp_fire = io.rsp_valid_in & io.rsp_ready_in;

  // Response demux: valid steered to one requester, tag/data broadcast.
  always_comb begin
    io.rsp_valid_out      = '0;
    io.rsp_valid_out[sel] = io.rsp_valid_in;
    io.rsp_ready_in       = io.rsp_ready_out[sel];
    for (int i = 0; i < NUM_REQS; i++) begin
      io.rsp_tag_out[i]  = io.rsp_tag_in[TAG_IN_WIDTH-1:0];
      io.rsp_data_out[i] = io.rsp_data_in;
    end
  end

  // Credit counters; an unexpected response never drives a counter below zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else begin
      for (int i = 0; i < NUM_REQS; i++) begin
        if (accept && grant_idx == req_idx_t'(i)) begin
          if (!(rsp_fire && sel == req_idx_t'(i))) begin
            pending[i] <= pending[i] + pend_t'(1);
          end
        end else if (rsp_fire && sel == req_idx_t'(i) && pending[i] != '0) begin
          pending[i] <= pending[i] - pend_t'(1);
        end
      end
    end
  end

  // A response must belong to a requester with an outstanding request.
  always @(posedge clk) begin
    if (!reset && rsp_fire) begin
      assert (pending[sel] != '0);
    end
  end

  assign io.dbg = {pending, ptr};

endmodule

// File: tb/tb_vx_mem_scheduler.sv
// Directed bench for vx_mem_scheduler: a cycle table for arbitration and
// response routing, plus hand sequences for stall, credit exhaustion,
// same-cycle accept/response and asynchronous reset.
module tb_vx_mem_scheduler;
  import vx_mem_scheduler_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  vx_mem_scheduler_if ifc ();

  vx_mem_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .io    (ifc)
  );

  // Clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid_in;
    logic        ready_out;
    logic        rsp_valid;
    logic [1:0]  rsp_idx;
    logic [3:0]  rsp_ready_out;
    logic [3:0]  e_ready_in;
    logic        e_valid_out;
    logic [1:0]  e_out_idx;
    logic [3:0]  e_rsp_valid_out;
    logic        e_rsp_ready_in;
    logic [11:0] e_pend;
    logic [1:0]  e_ptr;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [31:0] addr_of(int i);
    return 32'h1000_0000 + 32'(i) * 32'h100;
  endfunction

  function automatic logic [7:0] tag_of(int i);
    return 8'h40 + 8'(i);
  endfunction

  function automatic logic [9:0] otag_of(int i);
    logic [1:0] ix;
    ix = 2'(i);
    return {ix, tag_of(i)};
  endfunction

  function automatic logic [11:0] pk(int p3, int p2, int p1, int p0);
    return {3'(p3), 3'(p2), 3'(p1), 3'(p0)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic idle_inputs();
    ifc.req_valid_in  = '0;
    ifc.req_ready_out = 1'b1;
    ifc.rsp_valid_in  = 1'b0;
    ifc.rsp_tag_in    = '0;
    ifc.rsp_data_in   = '0;
    ifc.rsp_ready_out = 4'b1111;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tagname);
    check({tagname, " valid_out"}, 64'(ifc.req_valid_out), 64'd0);
    check({tagname, " addr_out"}, 64'(ifc.req_addr_out), 64'd0);
    check({tagname, " tag_out"}, 64'(ifc.req_tag_out), 64'd0);
    check({tagname, " pending"}, 64'(ifc.dbg.pending), 64'd0);
    check({tagname, " ptr"}, 64'(ifc.dbg.ptr), 64'd0);
  endtask

  initial begin
    int accepts;
    reset = 1'b1;
    for (int i = 0; i < NUM_REQS; i++) begin
      ifc.req_addr_in[i] = addr_of(i);
      ifc.req_tag_in[i]  = tag_of(i);
    end
    idle_inputs();

    // valid rdy rv idx rsp_rdy | e_rdy_in e_vo e_idx e_rvo e_rri e_pend e_ptr
    vecs[0] = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b1111, 4'b0001, 1'b0, 2'd0, 4'b0000, 1'b1, pk(0,0,0,0), 2'd0};
    vecs[1] = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b1111, 4'b0010, 1'b1, 2'd0, 4'b0000, 1'b1, pk(0,0,0,1), 2'd1};
    vecs[2] = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b1111, 4'b0100, 1'b1, 2'd1, 4'b0000, 1'b1, pk(0,0,1,1), 2'd2};
    vecs[3] = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b1111, 4'b1000, 1'b1, 2'd2, 4'b0000, 1'b1, pk(0,1,1,1), 2'd3};
    vecs[4] = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b1111, 4'b0001, 1'b1, 2'd3, 4'b0000, 1'b1, pk(1,1,1,1), 2'd0};
    vecs[5] = '{4'b0000, 1'b1, 1'b1, 2'd1, 4'b1111, 4'b0000, 1'b1, 2'd0, 4'b0010, 1'b1, pk(1,1,1,2), 2'd1};
    vecs[6] = '{4'b0000, 1'b0, 1'b1, 2'd3, 4'b0111, 4'b0000, 1'b0, 2'd0, 4'b1000, 1'b0, pk(1,1,0,2), 2'd1};
    vecs[7] = '{4'b0010, 1'b1, 1'b1, 2'd2, 4'b1111, 4'b0010, 1'b0, 2'd0, 4'b0100, 1'b1, pk(1,1,0,2), 2'd1};
    vecs[8] = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b1111, 4'b0000, 1'b1, 2'd1, 4'b0000, 1'b1, pk(1,0,1,2), 2'd2};

    do_reset();
    check_reset_state("reset");

    // Table: round-robin burst, response routing and backpressure on responses
    for (int v = 0; v < 9; v++) begin
      ifc.req_valid_in  = vecs[v].valid_in;
      ifc.req_ready_out = vecs[v].ready_out;
      ifc.rsp_valid_in  = vecs[v].rsp_valid;
      ifc.rsp_tag_in    = {vecs[v].rsp_idx, 8'(8'h90 + v)};
      ifc.rsp_data_in   = 64'hDEAD_0000_0000_0000 | 64'(v);
      ifc.rsp_ready_out = vecs[v].rsp_ready_out;
      #1;
      check($sformatf("v%0d ready_in", v), 64'(ifc.req_ready_in), 64'(vecs[v].e_ready_in));
      check($sformatf("v%0d valid_out", v), 64'(ifc.req_valid_out), 64'(vecs[v].e_valid_out));
      check($sformatf("v%0d rsp_valid_out", v), 64'(ifc.rsp_valid_out), 64'(vecs[v].e_rsp_valid_out));
      check($sformatf("v%0d rsp_ready_in", v), 64'(ifc.rsp_ready_in), 64'(vecs[v].e_rsp_ready_in));
      check($sformatf("v%0d pending", v), 64'(ifc.dbg.pending), 64'(vecs[v].e_pend));
      check($sformatf("v%0d ptr", v), 64'(ifc.dbg.ptr), 64'(vecs[v].e_ptr));
      if (vecs[v].e_valid_out) begin
        check($sformatf("v%0d tag_out", v), 64'(ifc.req_tag_out), 64'(otag_of(int'(vecs[v].e_out_idx))));
        check($sformatf("v%0d addr_out", v), 64'(ifc.req_addr_out), 64'(addr_of(int'(vecs[v].e_out_idx))));
      end
      if (vecs[v].rsp_valid) begin
        check($sformatf("v%0d rsp_tag_out", v), 64'(ifc.rsp_tag_out[3]), 64'(8'h90 + v));
        check($sformatf("v%0d rsp_data_out", v), 64'(ifc.rsp_data_out[0]), 64'hDEAD_0000_0000_0000 | 64'(v));
      end
      next_cycle();
    end

    // Downstream stall: output held, no grants, pointer frozen
    do_reset();
    ifc.req_valid_in = 4'b0001;
    next_cycle();
    ifc.req_valid_in  = 4'b1111;
    ifc.req_ready_out = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("stall%0d valid_out", c), 64'(ifc.req_valid_out), 64'd1);
      check($sformatf("stall%0d addr_out", c), 64'(ifc.req_addr_out), 64'(addr_of(0)));
      check($sformatf("stall%0d tag_out", c), 64'(ifc.req_tag_out), 64'(otag_of(0)));
      check($sformatf("stall%0d ready_in", c), 64'(ifc.req_ready_in), 64'd0);
      check($sformatf("stall%0d ptr", c), 64'(ifc.dbg.ptr), 64'd1);
      next_cycle();
    end
    ifc.req_ready_out = 1'b1;
    #1;
    check("stall release ready_in", 64'(ifc.req_ready_in), 64'b0010);
    next_cycle();
    check("stall release tag_out", 64'(ifc.req_tag_out), 64'(otag_of(1)));

    // Credit exhaustion: single requester, responses never return
    do_reset();
    ifc.req_valid_in = 4'b0100;
    accepts = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (ifc.req_ready_in[2]) accepts++;
      next_cycle();
    end
    check("credit accepts", 64'(accepts), 64'd4);
    check("credit ready_in", 64'(ifc.req_ready_in), 64'd0);
    check("credit pending", 64'(ifc.dbg.pending), 64'(pk(0,4,0,0)));

    // Same-cycle accept and response leaves the counter unchanged
    do_reset();
    ifc.req_valid_in = 4'b0010;
    next_cycle();
    next_cycle();
    check("same pending before", 64'(ifc.dbg.pending), 64'(pk(0,0,2,0)));
    ifc.rsp_valid_in = 1'b1;
    ifc.rsp_tag_in   = {2'd1, 8'h55};
    #1;
    check("same ready_in", 64'(ifc.req_ready_in), 64'b0010);
    check("same rsp_ready_in", 64'(ifc.rsp_ready_in), 64'd1);
    next_cycle();
    ifc.rsp_valid_in = 1'b0;
    #1;
    check("same pending after", 64'(ifc.dbg.pending), 64'(pk(0,0,2,0)));

    // Asynchronous reset in the middle of a burst
    ifc.req_valid_in = 4'b1111;
    next_cycle();
    next_cycle();
    #2;
    check("midreset valid_out before", 64'(ifc.req_valid_out), 64'd1);
    reset = 1'b1;
    #1;
    check_reset_state("midreset");
    @(posedge clk);
    #1 reset = 1'b0;
    idle_inputs();
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vx_mem_scheduler.md
VX_MEM_SCHEDULER -- requirements
Module: VX_mem_scheduler

Interface
REQ-001: NUM_REQS, 4, number of requesters sharing one read port (>=2).
REQ-002: ADDR_WIDTH, 32, request address width.
REQ-003: DATA_WIDTH, 64, response data width.
REQ-004: TAG_IN_WIDTH, 8, per-requester tag width.
REQ-005: MAX_PENDING, 4, outstanding-request credit limit per requester (>=1); LOG_NUM_REQS = clog2(NUM_REQS), TAG_OUT_WIDTH = TAG_IN_WIDTH + LOG_NUM_REQS.
REQ-006: clk  in  1  single clock; all state rising-edge.
REQ-007: reset  in  1  asynchronous, active-high reset.
REQ-008: req_valid_in  in  [NUM_REQS]  per-requester request valid.
REQ-009: req_addr_in  in  [NUM_REQS][ADDR_WIDTH]  per-requester address.
REQ-010: req_tag_in  in  [NUM_REQS][TAG_IN_WIDTH]  per-requester tag.
REQ-011: req_ready_in  out  [NUM_REQS]  per-requester accept.
REQ-012: req_valid_out  out  1  memory request valid (registered).
REQ-013: req_addr_out  out  [ADDR_WIDTH]  memory request address (registered).
REQ-014: req_tag_out  out  [TAG_OUT_WIDTH]  {requester index, tag}, index in MSBs.
REQ-015: req_ready_out  in  1  memory accepts request.
REQ-016: rsp_valid_in  in  1  memory response valid.
REQ-017: rsp_tag_in  in  [TAG_OUT_WIDTH]  response tag; MSBs select requester.
REQ-018: rsp_data_in  in  [DATA_WIDTH]  response data.
REQ-019: rsp_ready_in  out  1  response accept.
REQ-020: rsp_valid_out  out  [NUM_REQS]  per-requester response valid.
REQ-021: rsp_tag_out  out  [NUM_REQS][TAG_IN_WIDTH]  tag with index removed (broadcast).
REQ-022: rsp_data_out  out  [NUM_REQS][DATA_WIDTH]  response data (broadcast).
REQ-023: rsp_ready_out  in  [NUM_REQS]  per-requester response ready.

Function
REQ-024: Requester i SHALL be eligible iff req_valid_in[i] and pending[i] < MAX_PENDING.
REQ-025: Grant SHALL be round-robin among eligible requesters, searching from priority pointer p upward with wrap; at most one req_ready_in bit high per cycle.
REQ-026: req_ready_in[i] SHALL equal grant[i] & (~req_valid_out | req_ready_out); accept = valid & ready.
REQ-027: On accept from i, output register SHALL load addr and {i, tag} and assert req_valid_out next cycle (latency 1); p SHALL become (i+1) mod NUM_REQS; p unchanged otherwise.
REQ-028: Output register SHALL hold contents stable while req_valid_out & ~req_ready_out; drain-and-reload in one cycle SHALL sustain one request/cycle.
REQ-029: pending[i] SHALL +1 on accept from i, -1 on response fire (rsp_valid_in & rsp_ready_in) to i, unchanged when both occur same cycle; width clog2(MAX_PENDING+1).
REQ-030: Response path SHALL be combinational: sel = rsp_tag_in MSBs; rsp_valid_out[sel] = rsp_valid_in, others 0; rsp_ready_in = rsp_ready_out[sel].
REQ-031: Response to requester with pending = 0 SHALL raise a simulation assertion; counter SHALL stay at 0.

Reset
REQ-032: On reset: req_valid_out = 0, req_addr_out/req_tag_out = 0, all pending = 0, p = 0; rsp outputs follow inputs combinationally.
REQ-033: Reset mid-operation SHALL discard the buffered request; responses for pre-reset requests are untracked (REQ-031 applies).

Structure
REQ-034: TAG_OUT_WIDTH/LOG_NUM_REQS derivation and tag-index placement constants SHALL live in the shared VX_gpu_pkg.
REQ-035: Round-robin selection SHALL be a sub-module VX_rr_arbiter (request vector, enable, one-hot grant, index).

Verification
REQ-036: Reset, then req_valid_in=4'b1111, req_ready_out=1 -> grants 0,1,2,3,0 on consecutive cycles; req_valid_out from cycle 1.
REQ-037: Only requester 2 valid, rsp never returned, MAX_PENDING=4 -> exactly 4 accepts, then req_ready_in[2]=0 indefinitely.
REQ-038: req_ready_out=0 for 5 cycles with output loaded -> req_addr_out/req_tag_out stable, req_ready_in=0, pointer unchanged.
REQ-039: rsp_tag_in MSBs=3, rsp_ready_out[3]=0 -> rsp_valid_out=4'b1000, rsp_ready_in=0, pending[3] unchanged.
REQ-040: Same-cycle accept and response for requester 1 with pending=2 -> pending stays 2; reset asserted mid-burst -> req_valid_out=0 immediately (asynchronously), all pending=0.
